// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared opcodes, shift types and flag indices for the SIMPLE pipeline
package simple_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_NOP = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_IN  = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1101;
    localparam logic [3:0] OP_RSV = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SLR = 2'b01,
        SH_SRL = 2'b10,
        SH_SRA = 2'b11
    } shift_t;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic op_writes_back(input logic [3:0] op);
        return !(op == OP_CMP || op == OP_NOP || op == OP_OUT || op == OP_RSV || op == OP_HLT);
    endfunction

    // 0111 and the whole 11xx group pass operand a through and never touch flags
    function automatic logic op_sets_flags(input logic [3:0] op);
        return !(op == OP_NOP || op[3:2] == 2'b11);
    endfunction

endpackage

// File: rtl/simple_shifter.sv
// rtl/simple_shifter.sv - combinational 16-bit barrel shifter; carry-out only with SIMPLE_SHIFT_CARRY_EN
module simple_shifter
    import simple_pkg::*;
(
    input  logic [15:0] a,
    input  logic [3:0]  d,
    input  logic [1:0]  shift_type,
    output logic [15:0] result,
    output logic        cout
);

    always_comb begin
        case (shift_t'(shift_type))
            SH_SLL:  result = a << d;
            // a >> 16 is zero, so d = 0 leaves the rotate equal to a
            SH_SLR:  result = (a << d) | (a >> (5'd16 - {1'b0, d}));
            SH_SRL:  result = a >> d;
            default: result = $signed(a) >>> d;
        endcase
    end

`ifdef SIMPLE_SHIFT_CARRY_EN
    // 16 - d wraps to -d in 4 bits, which is the last bit pushed out of a left shift
    always_comb begin
        cout = 1'b0;
        if (d != 4'd0) begin
            case (shift_t'(shift_type))
                SH_SLL:  cout = a[4'd0 - d];
                SH_SLR:  cout = result[0];
                default: cout = a[d - 4'd1];
            endcase
        end
    end
`else
    assign cout = 1'b0;
`endif

endmodule

// File: rtl/phase3exe.sv
// rtl/phase3exe.sv - SIMPLE execute stage: ALU/shifter, SZCV flags, phase-4 register (SIMPLE_SHIFT_CARRY_EN optional)
module phase3exe
    import simple_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             stall,
    input  logic             flush,
    input  logic             alu_src1,
    input  logic             alu_src2,
    input  logic             alu_or_shifter,
    input  logic             as_bc,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] ar,
    input  logic [WIDTH-1:0] br,
    input  logic [WIDTH-1:0] pc_plus1,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] result_q,
    output logic [3:0]       szcv_q,
    output logic             valid_q,
    output logic             wb_q
);

    logic [WIDTH-1:0] a, b, alu_res, sh_res, res;
    logic [WIDTH:0]   sum, diff;
    logic             alu_c, alu_v, sh_c, c, v;
    logic [3:0]       flags_next;

    assign a    = alu_src1 ? pc_plus1 : ar;
    assign b    = alu_src2 ? imm : br;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // diff[WIDTH] is the borrow: set exactly when a < b unsigned
    always_comb begin
        alu_res = a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_MOV:  alu_res = b;
            default: alu_res = a;
        endcase
    end

    simple_shifter u_shifter (
        .a          (a),
        .d          (b[3:0]),
        .shift_type (opcode[1:0]),
        .result     (sh_res),
        .cout       (sh_c)
    );

    assign res = alu_or_shifter ? sh_res : alu_res;
    assign c   = alu_or_shifter ? sh_c : alu_c;
    assign v   = alu_or_shifter ? 1'b0 : alu_v;

    always_comb begin
        flags_next         = 4'b0000;
        flags_next[FLAG_S] = res[WIDTH-1];
        flags_next[FLAG_Z] = (res == '0);
        flags_next[FLAG_C] = c;
        flags_next[FLAG_V] = v;
    end

    // stall outranks flush; flush kills the slot but leaves result and flags alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            szcv_q   <= 4'b0000;
            valid_q  <= 1'b0;
            wb_q     <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                valid_q <= 1'b0;
                wb_q    <= 1'b0;
            end else begin
                valid_q  <= valid_in;
                result_q <= res;
                wb_q     <= valid_in && op_writes_back(opcode);
                if (valid_in && as_bc && op_sets_flags(opcode))
                    szcv_q <= flags_next;
            end
        end
    end

endmodule

// File: tb/tb_phase3exe.sv
// tb/tb_phase3exe.sv - directed and randomized checks of phase3exe against an arithmetic reference model
module tb_phase3exe;

    logic        clk = 1'b0;
    logic        rst_n, valid_in, stall, flush;
    logic        alu_src1, alu_src2, alu_or_shifter, as_bc;
    logic [3:0]  opcode;
    logic [15:0] ar, br, pc_plus1, imm;
    logic [15:0] result_q;
    logic [3:0]  szcv_q;
    logic        valid_q, wb_q;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_result;
    logic [3:0]  m_szcv;
    logic        m_valid, m_wb;

    always #5 clk = ~clk;

    phase3exe #(.WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .stall          (stall),
        .flush          (flush),
        .alu_src1       (alu_src1),
        .alu_src2       (alu_src2),
        .alu_or_shifter (alu_or_shifter),
        .as_bc          (as_bc),
        .opcode         (opcode),
        .ar             (ar),
        .br             (br),
        .pc_plus1       (pc_plus1),
        .imm            (imm),
        .result_q       (result_q),
        .szcv_q         (szcv_q),
        .valid_q        (valid_q),
        .wb_q           (wb_q)
    );

    function automatic void ref_exec(input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] op, input logic sh,
                                     output logic [15:0] r, output logic c, output logic v);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int t;
        int d;
        r = a;
        c = 1'b0;
        v = 1'b0;
        if (sh) begin
            d = ub % 16;
            if (d != 0) begin
                case (op[1:0])
                    2'b00: begin
                        t = ua * (1 << d);
                        r = t[15:0];
                        c = t[16];
                    end
                    2'b01: begin
                        t = ua;
                        for (int i = 0; i < d; i++)
                            t = ((t << 1) & 'hFFFF) | ((t >> 15) & 1);
                        r = t[15:0];
                        c = r[0];
                    end
                    2'b10: begin
                        t = ua / (1 << d);
                        r = t[15:0];
                        c = ((ua >> (d - 1)) & 1) != 0;
                    end
                    default: begin
                        t = sa >>> d;
                        r = t[15:0];
                        c = ((ua >> (d - 1)) & 1) != 0;
                    end
                endcase
            end
`ifndef SIMPLE_SHIFT_CARRY_EN
            c = 1'b0;
`endif
        end else begin
            case (op)
                4'd0: begin
                    t = ua + ub;
                    r = t[15:0];
                    c = t > 65535;
                    v = (sa + sb > 32767) || (sa + sb < -32768);
                end
                4'd1, 4'd5: begin
                    t = ua - ub;
                    r = t[15:0];
                    c = ua < ub;
                    v = (sa - sb > 32767) || (sa - sb < -32768);
                end
                4'd2: r = a & b;
                4'd3: r = a | b;
                4'd4: r = a ^ b;
                4'd6: r = b;
                default: r = a;
            endcase
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag);
        logic [15:0] r;
        logic        c, v;
        ref_exec(alu_src1 ? pc_plus1 : ar, alu_src2 ? imm : br, opcode, alu_or_shifter, r, c, v);
        if (!rst_n) begin
            m_result = 16'h0;
            m_szcv   = 4'h0;
            m_valid  = 1'b0;
            m_wb     = 1'b0;
        end else if (!stall) begin
            if (flush) begin
                m_valid = 1'b0;
                m_wb    = 1'b0;
            end else begin
                m_valid  = valid_in;
                m_result = r;
                m_wb     = valid_in && !(opcode inside {4'd5, 4'd7, 4'd13, 4'd14, 4'd15});
                if (valid_in && as_bc && !(opcode == 4'd7 || opcode >= 4'd12))
                    m_szcv = {r[15], r == 16'h0, c, v};
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_result"}, result_q, m_result);
        check({tag, "_szcv"}, {12'h0, szcv_q}, {12'h0, m_szcv});
        check({tag, "_valid"}, {15'h0, valid_q}, {15'h0, m_valid});
        check({tag, "_wb"}, {15'h0, wb_q}, {15'h0, m_wb});
    endtask

    task automatic issue(input logic s1, input logic s2, input logic sh, input logic abc,
                         input logic [3:0] op, input logic [15:0] a_v, input logic [15:0] b_v,
                         input logic [15:0] pc_v, input logic [15:0] im_v);
        rst_n = 1'b1; valid_in = 1'b1; stall = 1'b0; flush = 1'b0;
        alu_src1 = s1; alu_src2 = s2; alu_or_shifter = sh; as_bc = abc;
        opcode = op; ar = a_v; br = b_v; pc_plus1 = pc_v; imm = im_v;
    endtask

    initial begin
        logic [3:0] alu_ops [12];
        alu_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13, 4'd14, 4'd15};

        issue(0, 0, 0, 1, 4'd0, 16'h1111, 16'h2222, 16'h0, 16'h0);
        rst_n = 1'b0;
        tick("reset0");
        tick("reset1");
        check("reset_result", result_q, 16'h0000);
        check("reset_szcv", {12'h0, szcv_q}, 16'h0000);

        issue(0, 0, 0, 1, 4'b0000, 16'h7FFF, 16'h0001, 16'h0, 16'h0);
        tick("add_ovf");
        check("add_ovf_lit_res", result_q, 16'h8000);
        check("add_ovf_lit_szcv", {12'h0, szcv_q}, 16'h0009);
        check("add_ovf_lit_wb", {15'h0, wb_q}, 16'h0001);

        issue(0, 0, 0, 1, 4'b0101, 16'h1234, 16'h1234, 16'h0, 16'h0);
        tick("cmp_eq");
        check("cmp_eq_lit_szcv", {12'h0, szcv_q}, 16'h0004);
        check("cmp_eq_lit_wb", {15'h0, wb_q}, 16'h0000);
        check("cmp_eq_lit_valid", {15'h0, valid_q}, 16'h0001);

        issue(0, 1, 1, 1, 4'b1011, 16'h8001, 16'h0, 16'h0, 16'h0001);
        tick("sra");
        check("sra_lit_res", result_q, 16'hC000);
`ifdef SIMPLE_SHIFT_CARRY_EN
        check("sra_lit_szcv", {12'h0, szcv_q}, 16'h000A);
`else
        check("sra_lit_szcv", {12'h0, szcv_q}, 16'h0008);
`endif

        issue(0, 1, 1, 1, 4'b1000, 16'h8001, 16'h0, 16'h0, 16'h0010);
        tick("sll_d0");
        issue(0, 1, 1, 1, 4'b1001, 16'h8001, 16'h0, 16'h0, 16'h0001);
        tick("slr_1");
        issue(0, 1, 1, 1, 4'b1000, 16'h0003, 16'h0, 16'h0, 16'h000F);
        tick("sll_15");

        issue(0, 0, 0, 1, 4'b0000, 16'h0003, 16'h0004, 16'h0, 16'h0);
        tick("add37");
        stall = 1'b1;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            opcode = 4'b0001;
            ar = 16'($urandom);
            br = 16'($urandom);
            tick("stall_flush");
            check("stall_lit_res", result_q, 16'h0007);
            check("stall_lit_valid", {15'h0, valid_q}, 16'h0001);
        end

        issue(0, 0, 0, 1, 4'b0001, 16'h0005, 16'h0007, 16'h0, 16'h0);
        flush = 1'b1;
        tick("flush_sub");
        check("flush_lit_valid", {15'h0, valid_q}, 16'h0000);
        check("flush_lit_wb", {15'h0, wb_q}, 16'h0000);
        check("flush_lit_szcv", {12'h0, szcv_q}, 16'h0000);

        issue(0, 0, 0, 1, 4'b0000, 16'hFFFF, 16'h0001, 16'h0, 16'h0);
        tick("pre_reset");
        rst_n = 1'b0;
        stall = 1'b1;
        tick("reset_mid");
        check("reset_mid_lit_res", result_q, 16'h0000);
        check("reset_mid_lit_szcv", {12'h0, szcv_q}, 16'h0000);
        check("reset_mid_lit_valid", {15'h0, valid_q}, 16'h0000);

        issue(0, 1, 0, 1, 4'b0110, 16'h0, 16'h0, 16'h0, 16'hABCD);
        tick("mov");
        check("mov_lit_res", result_q, 16'hABCD);
        check("mov_lit_szcv", {12'h0, szcv_q}, 16'h0008);

        for (int n = 0; n < 400; n++) begin
            rst_n          = ($urandom_range(0, 63) != 0);
            stall          = ($urandom_range(0, 7) == 0);
            flush          = ($urandom_range(0, 7) == 0);
            valid_in       = ($urandom_range(0, 3) != 0);
            alu_src1       = 1'($urandom);
            alu_src2       = 1'($urandom);
            alu_or_shifter = 1'($urandom);
            as_bc          = ($urandom_range(0, 3) != 0);
            opcode         = alu_or_shifter ? 4'(8 + $urandom_range(0, 3))
                                            : alu_ops[$urandom_range(0, 11)];
            ar             = 16'($urandom);
            br             = ($urandom_range(0, 7) == 0) ? ar : 16'($urandom);
            pc_plus1       = 16'($urandom);
            imm            = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/phase3exe.md
# phase3exe

Execute stage of the SIMPLE 16-bit pipeline. Consumes the latched phase-3 control bundle (ALUSrc1, ALUSrc2, ALUorshifter, AS_BC, opcode) together with the operands read in phase 2. Computes the ALU or shifter result and the SZCV condition flags. Registers result, flags and a write-back qualifier into the phase-4 pipeline register, and honours pipeline stall and flush.

## Interface

Parameters:
- WIDTH, 16, datapath width; only 16 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- valid_in  in  1  phase-3 slot holds a real instruction.
- stall  in  1  hold all state this cycle.
- flush  in  1  kill the phase-3 instruction.
- alu_src1  in  1  first operand select: 0 = ar, 1 = pc_plus1.
- alu_src2  in  1  second operand select: 0 = br, 1 = imm.
- alu_or_shifter  in  1  result select: 0 = ALU, 1 = shifter.
- as_bc  in  1  1 = arithmetic/shift class; the instruction may update flags.
- opcode  in  4  instruction function field.
- ar, br, pc_plus1, imm  in  16 each  operand candidates.
- result_q  out  16  registered result to phase 4.
- szcv_q  out  4  flag register; bit 3 = S, bit 2 = Z, bit 1 = C, bit 0 = V.
- valid_q  out  1  phase-4 slot valid.
- wb_q  out  1  phase 4 must write result_q to a register.

## Operation

Operands:
- a = alu_src1 ? pc_plus1 : ar
- b = alu_src2 ? imm : br

ALU, used when alu_or_shifter = 0:
- 0000 ADD: a + b. C = carry out of bit 15. V = signed overflow.
- 0001 SUB: a - b. C = borrow (a < b unsigned). V = signed overflow.
- 0010 AND, 0011 OR, 0100 XOR: bitwise. C = 0, V = 0.
- 0101 CMP: computed exactly as SUB. Result is discarded (wb_q = 0).
- 0110 MOV: result = b. C = 0, V = 0.
- 0111, 1100–1111: result = a. Flags are never updated. wb_q = 1 only for 1100 (IN; phase 4 substitutes the input data).

Shifter, used when alu_or_shifter = 1:
- Shift amount d = b[3:0].
- opcode[1:0] selects the operation: 00 SLL, 01 SLR (rotate left), 10 SRL (logical right), 11 SRA (arithmetic right).
- V = 0.
- If d = 0: result = a and C = 0.

S and Z always derive from the 16-bit result: S = result[15], Z = (result == 0).

Update rules, evaluated per rising edge:
- Reset (rst_n = 0): result_q = 0, szcv_q = 0, valid_q = 0, wb_q = 0. Reset overrides stall and flush.
- Else if stall = 1: every output holds, even if flush = 1 (stall has priority over flush).
- Else if flush = 1: valid_q = 0 and wb_q = 0. result_q and szcv_q hold.
- Else: valid_q = valid_in and result_q = computed result.
  - wb_q = valid_in AND the opcode writes back.
  - szcv_q is loaded only if valid_in = 1, as_bc = 1, and the opcode is not in {0111, 1100–1111}.
- Invalid slots (valid_in = 0) never change szcv_q.

## Timing

- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one instruction per cycle when stall = 0.
- The flags produced by instruction k are visible on szcv_q in the cycle when instruction k+1 is in phase 3. The branch unit reads them there; no forwarding is required.
- Back-to-back flag writers: the later one wins, one cycle later.
- A stall lasting any number of cycles freezes all outputs bit-exactly.

## Configuration

- SIMPLE_SHIFT_CARRY_EN defined:
  - For d ≠ 0, shifts set C to the last bit shifted out.
  - SLL: C = a[16-d]. SRL and SRA: C = a[d-1]. SLR: C = result[0].
- SIMPLE_SHIFT_CARRY_EN undefined: C = 0 for all shifts, and the carry-out logic is absent.

## Structure

- Shared package simple_pkg holds:
  - opcode localparams (OP_ADD … OP_HLT);
  - shift-type codes;
  - flag bit indices FLAG_S, FLAG_Z, FLAG_C, FLAG_V.
- Sub-module simple_shifter: combinational 16-bit barrel shifter.
  - Inputs: a, d, type.
  - Outputs: result, cout.
  - cout is generated only under SIMPLE_SHIFT_CARRY_EN.
- The ALU, flag logic and output registers live in phase3exe.

## Test plan

- ADD overflow: ar = 0x7FFF, br = 0x0001, sources 0/0, opcode 0000, as_bc = 1 → result_q = 0x8000, szcv_q = 1001, wb_q = 1.
- CMP equal: ar = br = 0x1234, opcode 0101, as_bc = 1 → szcv_q = 0100, wb_q = 0, valid_q = 1.
- SRA: ar = 0x8001, imm = 0x0001, alu_src2 = 1, alu_or_shifter = 1, opcode 1011 → result_q = 0xC000. With the macro: szcv_q = 1010. Without it: szcv_q = 1000.
- Stall over flush: load ADD 0x0003 + 0x0004; then hold stall = 1 and flush = 1 for 3 cycles → result_q = 0x0007 and valid_q = 1 throughout.
- Flush: issue SUB 5 - 7 with flush = 1 → valid_q = 0, wb_q = 0, szcv_q unchanged from its previous value.
- Reset mid-stream: assert rst_n = 0 for one cycle while stall = 1 → all outputs 0 on the next edge. A following MOV with imm = 0xABCD gives result_q = 0xABCD and szcv_q = 1000.
